muldiv_unit: RTL and testbench
==============================

# muldiv_unit

- Iterative multiply/divide unit implementing the RV32M operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU), parametrised in operand width.
- Sits beside the single-cycle integer ALU in the execute stage.
- Accepts one operation through a valid/ready handshake, computes it over multiple cycles, and holds the result until the consumer takes it.
- Also reports a zero flag on the result.

## Interface

Parameters:
- `XLEN`, default 32: operand and result width. Must be even and ≥ 4.
- `CNT_W`, default `$clog2(XLEN)`: width of the iteration counter.

Ports:
- `clk`  in  1  — rising-edge clock.
- `reset`  in  1  — asynchronous, active-high reset.
- `in_valid`  in  1  — operation request.
- `in_ready`  out  1  — unit can accept. High only in IDLE.
- `op`  in  3  — RV32M funct3:
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU
- `srcA`  in  XLEN  — rs1 operand (multiplicand / dividend).
- `srcB`  in  XLEN  — rs2 operand (multiplier / divisor).
- `flush`  in  1  — synchronous abort of any in-flight operation.
- `out_valid`  out  1  — result available.
- `out_ready`  in  1  — consumer takes the result.
- `result`  out  XLEN  — operation result.
- `zero`  out  1  — `result == 0`. Meaningful only when `out_valid` is high.

## Operation

State machine with three states:
- **IDLE**
  - `in_ready`=1.
  - On `in_valid`: latch `op`, `srcA`, `srcB` and signs.
  - Special divide cases go directly to DONE. All other ops go to CALC with counter = XLEN-1.
- **CALC**
  - One radix-2 step per cycle.
  - When counter = 0, go to DONE.
- **DONE**
  - `out_valid`=1; `result` is stable.
  - On `out_ready`, go to IDLE.

Multiply:
- Operands are converted to magnitudes according to op:
  - MULH: both signed.
  - MULHSU: A signed, B unsigned.
  - MULHU and MUL: unsigned.
- Shift-add into a 2·XLEN product; negate at the end if the signs differ.
- MUL returns bits [XLEN-1:0]. MULH, MULHSU and MULHU return bits [2·XLEN-1:XLEN].

Divide:
- Restoring division on magnitudes.
- Quotient sign = sign(A) XOR sign(B). Remainder sign = sign(A). Both apply to the signed ops only.

Special cases (resolved in IDLE, no CALC):
- Divisor 0:
  - DIV/DIVU → all ones.
  - REM/REMU → `srcA`.
- Signed overflow (DIV/REM with `srcA` = 1 followed by XLEN-1 zeros and `srcB` = all ones):
  - DIV → `srcA`.
  - REM → 0.

`flush`:
- In any state, the next state is IDLE and the result is discarded.
- `flush` has priority over `in_valid` and `out_ready` in the same cycle.
- A request presented with `flush` high is not accepted.

Reset (asynchronous, any time, including mid-CALC):
- State IDLE.
- `in_ready`=1, `out_valid`=0, `result`=0, `zero`=1.
- Counter and datapath registers are 0.

## Timing

Accept edge: rising edge with `in_valid` and `in_ready` both high. Counting from it:
- Normal op: `out_valid` rises XLEN+1 edges later (33 cycles at XLEN=32), i.e. XLEN CALC cycles plus one finalise/sign-fix edge into DONE.
- Special divide case: `out_valid` rises 1 edge after accept.

Handshake and throughput:
- `result` and `zero` are registered and held constant while `out_valid` is high and `out_ready` is low.
- `in_ready` is low from the accept edge until the edge on which the result is consumed. There is no overlap.
- A new op can be accepted at the earliest one cycle after consume.
- Throughput: one op per XLEN+3 cycles when `out_ready` is tied high.

## Configuration

`MULDIV_FAST_MUL_EN`:
- **Defined:** all four multiply ops are computed with a single-cycle combinational XLEN×XLEN product in IDLE. They take the 1-edge path to DONE, like the special divide cases. Divide ops are unchanged.
- **Undefined:** multiply uses the iterative shift-add path with latency XLEN+1.

Results are bit-identical in both builds.

## Test plan

- **DIV with signed operands:** MUL then DIV. `srcA`=7, `srcB`=-3, XLEN=32. Expect:
  - MUL → 0xFFFFFFEB, `out_valid` 33 cycles after accept (1 cycle with `MULDIV_FAST_MUL_EN`).
  - DIV → 0xFFFFFFFE.
  - REM → 1.
- **High-half multiplies:** `srcA`=0x80000000, `srcB`=0xFFFFFFFF. Expect:
  - MULH → 0x00000000.
  - MULHSU → 0x80000000.
  - MULHU → 0x7FFFFFFF.
- **Divide by zero:** DIVU 5/0 → 0xFFFFFFFF. REM 5/0 → 5. Each with latency 1 edge.
- **Signed overflow:** DIV 0x80000000/-1 → 0x80000000. REM of the same → 0 with `zero`=1.
- **Backpressure:** hold `out_ready`=0 for 10 cycles after `out_valid`. Expect `result` stable, `in_ready`=0, and a second `in_valid` ignored. Then assert `out_ready` → `in_ready`=1 on the next cycle.
- **Flush and reset:** assert `flush` at CALC cycle 12 → IDLE next edge, with no `out_valid` pulse. Assert `reset` asynchronously mid-CALC → all outputs at their reset values immediately. A new DIVU 100/7 after reset → 14.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit (shift-add multiply, restoring divide) behind a valid/ready handshake.
// Optional build macro MULDIV_FAST_MUL_EN: multiplies use a single-cycle combinational product instead.
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] srcA,
    input  logic [XLEN-1:0] srcB,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [XLEN-1:0]  acc_q, acc_d;
    logic [XLEN-1:0]  lo_q, lo_d;
    logic [XLEN-1:0]  mag_q, mag_d;
    logic             neg_q, neg_d;
    logic             rem_neg_q, rem_neg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]  result_q, result_d;
    logic             zero_q, zero_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;

    // Operand decode for the request presented in IDLE.
    logic            a_signed, b_signed, sign_a, sign_b;
    logic [XLEN-1:0] mag_a, mag_b;
    logic            div_zero, div_ovf;

    assign a_signed = op[2] ? ~op[0] : (op == 3'b001 || op == 3'b010);
    assign b_signed = op[2] ? ~op[0] : (op == 3'b001);
    assign sign_a   = a_signed & srcA[XLEN-1];
    assign sign_b   = b_signed & srcB[XLEN-1];
    assign mag_a    = sign_a ? -srcA : srcA;
    assign mag_b    = sign_b ? -srcB : srcB;
    assign div_zero = (srcB == '0);
    assign div_ovf  = ~op[0] && (srcA == {1'b1, {(XLEN-1){1'b0}}}) && (srcB == '1);

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_prod;
    assign fast_prod = {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
`endif

    // One radix-2 step: {acc, lo} is the product shift register or the remainder/quotient pair.
    logic [XLEN:0] mul_sum;
    logic [XLEN:0] div_shift;
    logic          div_take;

    assign mul_sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, mag_q} : '0);
    assign div_shift = {acc_q, lo_q[XLEN-1]};
    assign div_take  = (div_shift >= {1'b0, mag_q});

    // Finalise edge: apply signs and pick the requested half/field.
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, fin_result;

    assign prod_fix   = neg_q ? -{acc_q, lo_q} : {acc_q, lo_q};
    assign quo_fix    = neg_q ? -lo_q : lo_q;
    assign rem_fix    = rem_neg_q ? -acc_q : acc_q;
    assign fin_result = op_q[2] ? (op_q[1] ? rem_fix : quo_fix)
                                : ((op_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN]);

    always_comb begin
        // NOTE: every _d starts from its _q so no path through this block can infer a latch.
        state_d     = state_q;
        op_d        = op_q;
        acc_d       = acc_q;
        lo_d        = lo_q;
        mag_d       = mag_q;
        neg_d       = neg_q;
        rem_neg_d   = rem_neg_q;
        cnt_d       = cnt_q;
        result_d    = result_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;

        if (flush) begin
            state_d     = S_IDLE;
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        op_d       = op;
                        neg_d      = sign_a ^ sign_b;
                        rem_neg_d  = op[2] & sign_a;
                        acc_d      = '0;
                        cnt_d      = CNT_W'(XLEN - 1);
                        in_ready_d = 1'b0;
                        state_d    = S_CALC;
                        if (op[2]) begin
                            lo_d  = mag_a;
                            mag_d = mag_b;
                            // Special cases preload quotient (lo) and remainder (acc) with no sign fix.
                            if (div_zero || div_ovf) begin
                                state_d   = S_DONE;
                                neg_d     = 1'b0;
                                rem_neg_d = 1'b0;
                                acc_d     = div_zero ? srcA : '0;
                                lo_d      = div_zero ? '1 : srcA;
                            end
                        end else begin
                            lo_d  = mag_b;
                            mag_d = mag_a;
`ifdef MULDIV_FAST_MUL_EN
                            {acc_d, lo_d} = fast_prod;
                            state_d       = S_DONE;
`endif
                        end
                    end
                end
                S_CALC: begin
                    if (op_q[2]) begin
                        acc_d = div_take ? XLEN'(div_shift - {1'b0, mag_q}) : div_shift[XLEN-1:0];
                        lo_d  = {lo_q[XLEN-2:0], div_take};
                    end else begin
                        acc_d = mul_sum[XLEN:1];
                        lo_d  = {mul_sum[0], lo_q[XLEN-1:1]};
                    end
                    if (cnt_q == '0) begin
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                S_DONE: begin
                    // First DONE cycle is the finalise edge; out_valid rises with the fixed result.
                    if (!out_valid_q) begin
                        result_d    = fin_result;
                        out_valid_d = 1'b1;
                    end else if (out_ready) begin
                        state_d     = S_IDLE;
                        out_valid_d = 1'b0;
                        in_ready_d  = 1'b1;
                    end
                end
                default: begin
                    state_d     = S_IDLE;
                    in_ready_d  = 1'b1;
                    out_valid_d = 1'b0;
                end
            endcase
        end

        zero_d = (result_d == '0);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            acc_q       <= '0;
            lo_q        <= '0;
            mag_q       <= '0;
            neg_q       <= 1'b0;
            rem_neg_q   <= 1'b0;
            cnt_q       <= '0;
            result_q    <= '0;
            zero_q      <= 1'b1;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            acc_q       <= acc_d;
            lo_q        <= lo_d;
            mag_q       <= mag_d;
            neg_q       <= neg_d;
            rem_neg_q   <= rem_neg_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed testbench for muldiv_unit at XLEN=32: results, latency, backpressure, flush and async reset.
// Honours MULDIV_FAST_MUL_EN for the expected multiply latency.
module tb_muldiv_unit;

    localparam int XLEN = 32;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = XLEN + 1;
`endif
    localparam int DIV_LAT = XLEN + 1;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            in_valid = 1'b0;
    logic            flush = 1'b0;
    logic            out_ready = 1'b0;
    logic [2:0]      op = 3'b000;
    logic [XLEN-1:0] srcA = '0;
    logic [XLEN-1:0] srcB = '0;
    logic            in_ready;
    logic            out_valid;
    logic            zero;
    logic [XLEN-1:0] result;

    muldiv_unit #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .srcA      (srcA),
        .srcB      (srcB),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        string           name;
        logic [2:0]      op;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [XLEN-1:0] exp;
        int              lat;
    } vec_t;

    localparam int N_VEC = 16;
    vec_t vecs [N_VEC] = '{
        '{"MUL 7*-3",          3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT},
        '{"DIV 7/-3",          3'b100, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFE, DIV_LAT},
        '{"REM 7%-3",          3'b110, 32'd7,          32'hFFFF_FFFD, 32'd1,         DIV_LAT},
        '{"MULH min*-1",       3'b001, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, MUL_LAT},
        '{"MULHSU min*max",    3'b010, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, MUL_LAT},
        '{"MULHU min*max",     3'b011, 32'h8000_0000,  32'hFFFF_FFFF, 32'h7FFF_FFFF, MUL_LAT},
        '{"DIVU 5/0",          3'b101, 32'd5,          32'd0,         32'hFFFF_FFFF, 1},
        '{"REM 5/0",           3'b110, 32'd5,          32'd0,         32'd5,         1},
        '{"DIV ovf",           3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1},
        '{"REM ovf",           3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1},
        '{"DIV -7/2",          3'b100, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, DIV_LAT},
        '{"REM -7/2",          3'b110, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, DIV_LAT},
        '{"REMU 100/7",        3'b111, 32'd100,        32'd7,         32'd2,         DIV_LAT},
        '{"MUL lo",            3'b000, 32'h1234_5678,  32'h10,        32'h2345_6780, MUL_LAT},
        '{"MULHU max*max",     3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT},
        '{"DIVU max/16",       3'b101, 32'hFFFF_FFFF,  32'h10,        32'h0FFF_FFFF, DIV_LAT}
    };

    // Present one op, measure edges from accept to out_valid, check and consume the result.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [XLEN-1:0] a,
                          input logic [XLEN-1:0] b, input logic [XLEN-1:0] exp, input int lat);
        int n;
        @(negedge clk);
        check({tag, " in_ready before"}, 64'(in_ready), 64'(1));
        op       = o;
        srcA     = a;
        srcB     = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, " latency"}, 64'(n), 64'(lat));
        check({tag, " result"}, 64'(result), 64'(exp));
        check({tag, " zero"}, 64'(zero), 64'(exp == '0));
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, " out_valid after consume"}, 64'(out_valid), 64'(0));
        check({tag, " in_ready after consume"}, 64'(in_ready), 64'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int hits;

        // Power-on reset
        #2 reset = 1'b1;
        #1;
        check("reset in_ready", 64'(in_ready), 64'(1));
        check("reset out_valid", 64'(out_valid), 64'(0));
        check("reset result", 64'(result), 64'(0));
        check("reset zero", 64'(zero), 64'(1));
        repeat (2) @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < N_VEC; i++) begin
            run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);
        end

        // Backpressure: hold the result for 10 cycles while a second request is offered.
        @(negedge clk);
        op = 3'b101; srcA = 32'd100; srcB = 32'd7; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("bp latency", 64'(n), 64'(DIV_LAT));
        @(negedge clk);
        op = 3'b000; srcA = 32'd3; srcB = 32'd3; in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            check("bp result held", 64'(result), 64'(14));
            check("bp in_ready low", 64'(in_ready), 64'(0));
            check("bp out_valid held", 64'(out_valid), 64'(1));
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("bp in_ready after consume", 64'(in_ready), 64'(1));
        check("bp out_valid after consume", 64'(out_valid), 64'(0));

        // Flush at CALC cycle 12, then a request offered together with flush.
        @(negedge clk);
        op = 3'b101; srcA = 32'd1000; srcB = 32'd3; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (11) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        check("flush in_ready", 64'(in_ready), 64'(1));
        check("flush out_valid", 64'(out_valid), 64'(0));
        @(negedge clk);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        check("flush blocks accept", 64'(in_ready), 64'(1));
        @(negedge clk);
        in_valid = 1'b0;
        flush    = 1'b0;
        hits = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (out_valid) hits++;
        end
        check("flush no out_valid pulse", 64'(hits), 64'(0));

        // Asynchronous reset mid-CALC; result register still holds 14 from the backpressure op.
        @(negedge clk);
        op = 3'b101; srcA = 32'd1000; srcB = 32'd3; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("async reset in_ready", 64'(in_ready), 64'(1));
        check("async reset out_valid", 64'(out_valid), 64'(0));
        check("async reset result", 64'(result), 64'(0));
        check("async reset zero", 64'(zero), 64'(1));
        @(negedge clk);
        reset = 1'b0;

        run_op("DIVU 100/7 after reset", 3'b101, 32'd100, 32'd7, 32'd14, DIV_LAT);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
